// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit start validation, centre sampling
// of data/stop bits from an internal bit-period counter, valid/ack byte delivery.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 2618,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             framing_error_q, framing_error_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             deliver;

  // State and output registers; synchronizer flops reset to the idle line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q            <= 1'b1;
      s2_q            <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      s1_q            <= rx;
      s2_q            <= s1_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
      busy_q          <= busy_d;
    end
  end

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    rx_data_d       = rx_data_q;
    framing_error_d = 1'b0;
    deliver         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!s2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = s2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s2_q) begin
            deliver   = 1'b1;
            rx_data_d = shift_q;
            state_d   = IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Delivery beats a same-cycle ack; overrun only when the old byte was never taken.
    rx_valid_d = rx_valid_q;
    if (rx_ack && rx_valid_q) rx_valid_d = 1'b0;
    if (deliver) rx_valid_d = 1'b1;
    overrun_d = deliver && rx_valid_q && !rx_ack;
    busy_d    = (state_d != IDLE);
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with CLKS_PER_BIT=16.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e_cyc = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic prev_valid = 1'b0;
  int fe0, ov0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters and rx_valid rise-edge timestamp, sampled mid-cycle.
  always @(negedge clock) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive one 8N1 frame on negedges; optionally pulse rx_ack on the stop-sample edge.
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
    rx = 1'b0;
    e_cyc = cyc + 1;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_bit;
    cycles(10);
    rx_ack = ack_at_stop;
    cycles(1);
    rx_ack = 1'b0;
    cycles(5);
    rx = 1'b1;
  endtask

  task automatic ack_byte();
    rx_ack = 1'b1;
    cycles(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ack = 1'b0;
    cycles(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fe", framing_error, 0);
    chk("reset_ov", overrun, 0);
    reset = 1'b0;
    cycles(3);

    // Single frame with exact delivery latency.
    fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'hA5, 1'b1, 1'b0);
    chk("a5_rise_time", rise_cyc - e_cyc, 154);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    ack_byte();
    chk("a5_valid_after_ack", rx_valid, 0);
    chk("a5_data_after_ack", rx_data, 8'hA5);
    chk("a5_no_fe", fe_cnt - fe0, 0);
    chk("a5_no_ov", ov_cnt - ov0, 0);
    ack_byte();
    chk("stray_ack_ignored", rx_valid, 0);
    cycles(4);

    // Unacked byte, then next delivery coincides with ack: delivery wins, no overrun.
    send(8'h5A, 1'b1, 1'b0);
    chk("5a_data", rx_data, 8'h5A);
    ov0 = ov_cnt;
    send(8'hC3, 1'b1, 1'b1);
    cycles(2);
    chk("sim_ack_valid", rx_valid, 1);
    chk("sim_ack_data", rx_data, 8'hC3);
    chk("sim_ack_no_ov", ov_cnt - ov0, 0);
    ack_byte();
    chk("c3_acked", rx_valid, 0);
    cycles(4);

    // Glitch: 4-cycle low pulse is rejected at the start-bit centre.
    fe0 = fe_cnt;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(10);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    // Framing error: stop bit 0, byte dropped, next frame fine.
    fe0 = fe_cnt;
    send(8'h3C, 1'b0, 1'b0);
    cycles(5);
    chk("fe_count", fe_cnt - fe0, 1);
    chk("fe_valid", rx_valid, 0);
    chk("fe_data_kept", rx_data, 8'hC3);
    chk("fe_idle", busy, 0);
    send(8'h55, 1'b1, 1'b0);
    chk("55_data", rx_data, 8'h55);
    chk("55_valid", rx_valid, 1);
    ack_byte();
    cycles(4);

    // Break: long low line yields exactly one framing error.
    fe0 = fe_cnt;
    rx = 1'b0;
    cycles(400);
    chk("break_busy_low", busy, 1);
    rx = 1'b1;
    cycles(20);
    chk("break_fe_count", fe_cnt - fe0, 1);
    chk("break_valid", rx_valid, 0);
    chk("break_idle", busy, 0);

    // Overrun: two frames back-to-back without ack.
    ov0 = ov_cnt;
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    cycles(3);
    chk("ov_count", ov_cnt - ov0, 1);
    chk("ov_data", rx_data, 8'h34);
    chk("ov_valid", rx_valid, 1);

    // Reset after bit 3 of 0xFF aborts the frame.
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      cycles(CPB);
    end
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    rx = 1'b1;
    cycles(2);
    chk("mid_reset_data", rx_data, 8'h00);
    chk("mid_reset_valid", rx_valid, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_fe", framing_error, 0);
    chk("mid_reset_ov", overrun, 0);
    reset = 1'b0;
    cycles(CPB * 6);
    chk("mid_no_partial", rx_valid, 0);
    send(8'h81, 1'b1, 1'b0);
    chk("81_data", rx_data, 8'h81);
    chk("81_valid", rx_valid, 1);
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
